// File: rtl/header.sv
// Shared definitions for the decode stage.
// Holds the opcode enum, NZCV flag bit positions, the control-bit struct,
// the source-use mask struct and the branch-condition helper.
package header;

  localparam int unsigned OP_BITS = 8;

  // Flag register bit positions, ordered [0:3] = N, Z, C, V.
  localparam int unsigned N_IDX = 0;
  localparam int unsigned Z_IDX = 1;
  localparam int unsigned C_IDX = 2;
  localparam int unsigned V_IDX = 3;

  typedef enum logic [OP_BITS-1:0] {
    STALL = 8'd0,
    ADD   = 8'd1,
    ADDI  = 8'd2,
    SUB   = 8'd3,
    SUBI  = 8'd4,
    CMP   = 8'd5,
    CMPI  = 8'd6,
    MOV   = 8'd7,
    MOVI  = 8'd8,
    LDR   = 8'd9,
    STR   = 8'd10,
    B     = 8'd11,
    BEQ   = 8'd12,
    BNE   = 8'd13,
    BGT   = 8'd14,
    BGE   = 8'd15,
    BLT   = 8'd16,
    BLE   = 8'd17,
    BR    = 8'd18,
    BEQR  = 8'd19,
    BNER  = 8'd20,
    BGTR  = 8'd21,
    BGER  = 8'd22,
    BLTR  = 8'd23,
    BLER  = 8'd24
  } opcode;

  typedef struct packed {
    logic regwrite;
    logic use_imm;
    logic memwrite;
    logic memtoreg;
    logic setflags;
    logic branch;
  } ctrl_t;

  // Which register fields the instruction reads (rd also covers the write target).
  typedef struct packed {
    logic rd;
    logic ra;
    logic rb;
  } src_use_t;

  // Branch outcome from N and Z; register forms share the immediate-form conditions.
  function automatic logic branch_taken(opcode op, logic n, logic z);
    logic taken;
    case (op)
      B, BR:       taken = 1'b1;
      BEQ, BEQR:   taken = z;
      BNE, BNER:   taken = ~z;
      BGT, BGTR:   taken = ~n & ~z;
      BGE, BGER:   taken = ~n | z;
      BLT, BLTR:   taken = n & ~z;
      BLE, BLER:   taken = n | z;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder.
// Ports:
//   instr        instruction, bit 0 is the MSB
//   eff_flags    effective NZCV flags used to resolve branches
//   op, rd, ra, rb, imm  extracted fields
//   ctrl         control bits (branch = taken)
//   src_use      register fields the instruction depends on
//   cond_branch  instruction is a conditional branch
//   op_valid     opcode is defined and not STALL (produces an output beat)
module decode_logic
  import header::*;
#(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned OPC_W      = 8,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned IMM_W      = 16
) (
  input  logic [0:INSTR_W-1]    instr,
  input  logic [0:3]            eff_flags,
  output opcode                 op,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] ra,
  output logic [REG_ADDR_W-1:0] rb,
  output logic [IMM_W-1:0]      imm,
  output ctrl_t                 ctrl,
  output src_use_t              src_use,
  output logic                  cond_branch,
  output logic                  op_valid
);

  logic unused_cv;

  assign op  = opcode'(instr[0:OPC_W-1]);
  assign rd  = instr[OPC_W +: REG_ADDR_W];
  assign ra  = instr[OPC_W + REG_ADDR_W +: REG_ADDR_W];
  assign rb  = instr[OPC_W + 2 * REG_ADDR_W +: REG_ADDR_W];
  assign imm = instr[INSTR_W - IMM_W +: IMM_W];

  // C and V do not take part in any branch condition.
  assign unused_cv = eff_flags[C_IDX] ^ eff_flags[V_IDX];

  always_comb begin
    ctrl          = '0;
    ctrl.regwrite = 1'b1;
    src_use       = '0;
    cond_branch   = 1'b0;
    op_valid      = 1'b1;
    case (op)
      ADD, SUB: begin
        ctrl.setflags = 1'b1;
        src_use.ra    = 1'b1;
        src_use.rb    = 1'b1;
      end
      ADDI, SUBI: begin
        ctrl.setflags = 1'b1;
        ctrl.use_imm  = 1'b1;
        src_use.ra    = 1'b1;
      end
      CMP: begin
        ctrl.regwrite = 1'b0;
        ctrl.setflags = 1'b1;
        src_use.ra    = 1'b1;
        src_use.rb    = 1'b1;
      end
      CMPI: begin
        ctrl.regwrite = 1'b0;
        ctrl.setflags = 1'b1;
        ctrl.use_imm  = 1'b1;
        src_use.ra    = 1'b1;
      end
      MOV: src_use.ra = 1'b1;
      MOVI: ctrl.use_imm = 1'b1;
      LDR: begin
        ctrl.memtoreg = 1'b1;
        src_use.ra    = 1'b1;
      end
      STR: begin
        ctrl.regwrite = 1'b0;
        ctrl.memwrite = 1'b1;
        src_use.ra    = 1'b1;
        src_use.rd    = 1'b1;
      end
      B, BEQ, BNE, BGT, BGE, BLT, BLE: begin
        ctrl.regwrite = 1'b0;
        ctrl.use_imm  = 1'b1;
        ctrl.branch   = branch_taken(op, eff_flags[N_IDX], eff_flags[Z_IDX]);
        cond_branch   = (op != B);
      end
      BR, BEQR, BNER, BGTR, BGER, BLTR, BLER: begin
        ctrl.regwrite = 1'b0;
        src_use.ra    = 1'b1;
        ctrl.branch   = branch_taken(op, eff_flags[N_IDX], eff_flags[Z_IDX]);
        cond_branch   = (op != BR);
      end
      default: begin
        // STALL and undefined encodings become bubbles.
        ctrl.regwrite = 1'b0;
        op_valid      = 1'b0;
      end
    endcase
    // A written rd is checked too, so a pending write to it holds the instruction off.
    src_use.rd = src_use.rd | ctrl.regwrite;
  end

endmodule

// File: rtl/decode_unit.sv
// Pipelined decode stage between fetch and execute.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake; in_instr, in_pc
//   out_valid/out_ready      execute handshake; out_op, out_rd/ra/rb, out_imm, out_pc,
//                            out_regwrite/use_imm/memwrite/memtoreg/setflags/branch
//   wb_valid, wb_addr        completed register write (clears scoreboard bit)
//   flags_valid, flags_in    NZCV reported by execute
//   flags                    architectural flag register
//   flush                    kill the beat held in the output register
module decode_unit
  import header::*;
#(
  parameter int unsigned INSTR_W           = 32,
  parameter int unsigned OPC_W             = 8,
  parameter int unsigned REG_ADDR_W        = 4,
  parameter int unsigned IMM_W             = 16,
  parameter int unsigned PC_W              = 16,
  parameter int unsigned MAX_FLAG_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:INSTR_W-1]    in_instr,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output opcode                 out_op,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_ra,
  output logic [REG_ADDR_W-1:0] out_rb,
  output logic [IMM_W-1:0]      out_imm,
  output logic [PC_W-1:0]       out_pc,
  output logic                  out_regwrite,
  output logic                  out_use_imm,
  output logic                  out_memwrite,
  output logic                  out_memtoreg,
  output logic                  out_setflags,
  output logic                  out_branch,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  flags_valid,
  input  logic [0:3]            flags_in,
  output logic [0:3]            flags,
  input  logic                  flush
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = $clog2(MAX_FLAG_INFLIGHT + 1);

  logic [0:3]            eff_flags;
  opcode                 dec_op;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [REG_ADDR_W-1:0] dec_ra;
  logic [REG_ADDR_W-1:0] dec_rb;
  logic [IMM_W-1:0]      dec_imm;
  ctrl_t                 dec_ctrl;
  src_use_t              dec_use;
  logic                  dec_cond;
  logic                  dec_valid;

  logic [NUM_REGS-1:0]   sb_q, sb_d, wb_clr, sb_eff;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_after_dec;
  logic [CNT_W:0]        cnt_inc;
  logic [1:0]            cnt_dec;
  logic                  hazard, accept, flush_kill;

  assign eff_flags = flags_valid ? flags_in : flags;

  decode_logic #(
    .INSTR_W    (INSTR_W),
    .OPC_W      (OPC_W),
    .REG_ADDR_W (REG_ADDR_W),
    .IMM_W      (IMM_W)
  ) u_decode_logic (
    .instr       (in_instr),
    .eff_flags   (eff_flags),
    .op          (dec_op),
    .rd          (dec_rd),
    .ra          (dec_ra),
    .rb          (dec_rb),
    .imm         (dec_imm),
    .ctrl        (dec_ctrl),
    .src_use     (dec_use),
    .cond_branch (dec_cond),
    .op_valid    (dec_valid)
  );

  always_comb begin
    wb_clr = '0;
    if (wb_valid) wb_clr[wb_addr] = 1'b1;
  end

  // Same-cycle writeback bypasses the scoreboard so the dependent can go immediately.
  assign sb_eff        = sb_q & ~wb_clr;
  assign cnt_after_dec = (flags_valid && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

  always_comb begin
    hazard = 1'b0;
    if (dec_valid) begin
      if (dec_use.ra && sb_eff[dec_ra]) hazard = 1'b1;
      if (dec_use.rb && sb_eff[dec_rb]) hazard = 1'b1;
      if (dec_use.rd && sb_eff[dec_rd]) hazard = 1'b1;
      if (dec_cond && cnt_after_dec != '0) hazard = 1'b1;
      if (dec_ctrl.setflags && cnt_q == CNT_W'(MAX_FLAG_INFLIGHT) && !flags_valid) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready   = (~out_valid | out_ready) & ~hazard & ~flush & ~rst;
  assign accept     = in_valid & in_ready;
  assign flush_kill = flush & out_valid;

  always_comb begin
    sb_d = sb_q & ~wb_clr;
    // A killed beat will never write back, so release its destination.
    if (flush_kill && out_regwrite) sb_d[out_rd] = 1'b0;
    if (accept && dec_valid && dec_ctrl.regwrite) sb_d[dec_rd] = 1'b1;
  end

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, accept & dec_ctrl.setflags};
    cnt_dec = {1'b0, flags_valid} + {1'b0, flush_kill & out_setflags};
    if (cnt_inc <= {{(CNT_W - 1){1'b0}}, cnt_dec}) cnt_d = '0;
    else cnt_d = CNT_W'(cnt_inc - {{(CNT_W - 1){1'b0}}, cnt_dec});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
      flags <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      if (flags_valid) flags <= flags_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_op       <= STALL;
      out_rd       <= '0;
      out_ra       <= '0;
      out_rb       <= '0;
      out_imm      <= '0;
      out_pc       <= '0;
      out_regwrite <= 1'b0;
      out_use_imm  <= 1'b0;
      out_memwrite <= 1'b0;
      out_memtoreg <= 1'b0;
      out_setflags <= 1'b0;
      out_branch   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= dec_valid;
      out_op       <= dec_valid ? dec_op : STALL;
      out_rd       <= dec_rd;
      out_ra       <= dec_ra;
      out_rb       <= dec_rb;
      out_imm      <= dec_imm;
      out_pc       <= in_pc;
      out_regwrite <= dec_ctrl.regwrite;
      out_use_imm  <= dec_ctrl.use_imm;
      out_memwrite <= dec_ctrl.memwrite;
      out_memtoreg <= dec_ctrl.memtoreg;
      out_setflags <= dec_ctrl.setflags;
      out_branch   <= dec_ctrl.branch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_unit.md
# decode_unit

Pipelined, parametrised decode stage between fetch and execute. Splits each instruction into opcode, register and immediate fields, generates the control bits, and resolves conditional branches against an architectural NZCV flag register. A per-register scoreboard and an in-flight flag counter stall on hazards. Fetch and execute connect through valid/ready handshakes, and a registered output gives one cycle of latency.

## Interface
Parameters:
- INSTR_W, 32, instruction width; bit 0 is the MSB (`[0:INSTR_W-1]`)
- OPC_W, 8, opcode field width
- REG_ADDR_W, 4, register address width; NUM_REGS = 2**REG_ADDR_W
- IMM_W, 16, immediate width (low IMM_W bits of instr)
- PC_W, 16, program counter width
- MAX_FLAG_INFLIGHT, 4, maximum number of accepted, unresolved flag-setting instructions

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid / in_ready  in / out  1  fetch handshake
- in_instr  in  INSTR_W  instruction
- in_pc  in  PC_W  instruction address
- out_valid / out_ready  out / in  1  execute handshake
- out_op  out  OPC_W  opcode (package enum)
- out_rd, out_ra, out_rb  out  REG_ADDR_W  destination and sources
- out_imm  out  IMM_W  immediate
- out_pc  out  PC_W  passed through
- out_regwrite, out_use_imm, out_memwrite, out_memtoreg, out_setflags, out_branch  out  1 each  control
- wb_valid, wb_addr  in  1, REG_ADDR_W  a register write completed
- flags_valid, flags_in  in  1, 4  execute reports NZCV, order [0:3] = N,Z,C,V
- flags  out  4  architectural flag register
- flush  in  1  kill the contents of the output register

## Operation
- Fields: op=instr[0:OPC_W-1]; rd, ra, rb follow in that order, REG_ADDR_W bits each; imm=instr[INSTR_W-IMM_W:INSTR_W-1].
- Control defaults: regwrite=1, all other control bits 0.
- Immediate ("I") forms: use_imm=1.
- setflags=1 for ADD, ADDI, SUB, SUBI, CMP, CMPI. CMP and CMPI have regwrite=0.
- LDR: memtoreg=1, regwrite=1.
- STR: memwrite=1, regwrite=0.
- All branches: regwrite=0. Immediate branch forms: use_imm=1.
- Branch conditions, evaluated on effective flags:
  - B, BR: taken unconditionally
  - EQ: Z
  - NE: ~Z
  - GT: ~N&~Z
  - GE: ~N|Z
  - LT: N&~Z
  - LE: N|Z
  - Register forms use the same conditions as immediate forms.
- Effective flags = flags_in when flags_valid is high, else the flags register.
- STALL and undefined opcodes: consumed (in_ready honoured) but produce no output beat (bubble).
- Sources used:
  - ra: used by every opcode except MOVI, B-immediate forms and STALL.
  - rb: used when use_imm=0 and the op reads two registers.
  - STR: reads rd as data.
- Scoreboard (NUM_REGS bits):
  - Bit rd set on accept of a regwrite instruction.
  - Bit wb_addr cleared on wb_valid.
  - Set and clear of the same bit in the same cycle: set wins.
- Flag counter (0..MAX_FLAG_INFLIGHT):
  - +1 on accept of a setflags instruction.
  - −1 on flags_valid.
  - Both in the same cycle: net 0.
- Hazard (held off, in_ready=0); the scoreboard is evaluated after the same-cycle wb clear (bypass):
  - Any used source or rd has its scoreboard bit set.
  - Conditional branch while counter_after_dec ≠ 0.
  - setflags instruction while counter == MAX_FLAG_INFLIGHT and flags_valid is low.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst.
- flush:
  - Clears out_valid the next cycle.
  - If the flushed beat had regwrite, clears its rd scoreboard bit.
  - If it had setflags, decrements the counter (combined with any flags_valid decrement).
  - Accepts nothing that cycle.
- Reset:
  - out_valid=0, flags=0, scoreboard=0, counter=0.
  - All out_* fields and control bits 0; out_op=STALL.
  - Reset mid-stall discards everything.

## Timing
- Accept at edge N makes the decoded beat visible, with out_valid=1, after edge N.
- Output holds stable while out_valid & ~out_ready.
- Back-to-back accepts are possible when out_ready=1 and there is no hazard.
- flags updates on the edge after flags_valid.
- Branch condition is sampled in the accept cycle and registered into out_branch.
- wb_valid in cycle N unblocks a dependent instruction in the same cycle N.

## Structure
- Package `header` holds the `opcode` enum (STALL=0 plus the full ISA), the flag index constants N_IDX..V_IDX, and the `ctrl_t` packed struct of control bits.
- Sub-module `decode_logic`: purely combinational; instr + effective flags → fields, ctrl_t, and a source-use mask.
- `decode_unit` contains the handshake, pipeline register, scoreboard, flag counter and flag register.

## Test plan
- ADDI r1,r2,#5 with out_ready=1 → one cycle later: out_valid=1, rd=1, ra=2, imm=5, use_imm=1, setflags=1; scoreboard bit 1 set.
- ADD r3,r1,r1 immediately after → in_ready=0 until wb_valid with wb_addr=1; accepted in that same cycle.
- CMP, then BEQ → BEQ stalls; flags_valid with Z=1 arrives → BEQ accepted the same cycle with out_branch=1; flags=0100 next cycle.
- out_ready=0 for 3 cycles with a held beat → outputs unchanged and in_ready=0; release → the next instruction follows.
- flush while the output holds LDR r4 → out_valid=0 next cycle; scoreboard bit 4 cleared; an instruction reading r4 is accepted without stalling.
- 4 SUBIs with no flags_valid → the 5th SUBI stalls; one flags_valid releases it.
